// File: rtl/mvu_rdc_reader.sv
// mvu_rdc_reader
// Streams a burst of words out of the MVU data memory. A command supplies a
// start address and a word count. The block issues one read per cycle while
// there is room downstream, follows each read through the fixed memory
// latency, and buffers the returned words in a small FIFO for the consumer.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   cmd_valid/ready        command handshake; cmd_baddr start, cmd_len count
//   mvu_rdc_en/grnt/addr   memory read request handshake
//   mvu_rdc_word           read data, RD_LAT cycles after the grant
//   out_valid/ready        output handshake; out_data word, out_last tag
//   busy                   a command is in progress
//   done                   one-cycle pulse when a command completes
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a command; cmd_ready high
// ST_REQ   | issuing reads while FIFO plus in-flight reads leave room
// ST_DRAIN | all reads issued; waiting for the last word to be popped
module mvu_rdc_reader #(
  parameter int BDBANKA    = 15,
  parameter int BDBANKW    = 64,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [BDBANKA-1:0] cmd_baddr,
  input  logic [15:0]        cmd_len,
  output logic               mvu_rdc_en,
  input  logic               mvu_rdc_grnt,
  output logic [BDBANKA-1:0] mvu_rdc_addr,
  input  logic [BDBANKW-1:0] mvu_rdc_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BDBANKW-1:0] out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  // wide enough for FIFO occupancy plus every in-flight read
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [BDBANKA-1:0]   addr_q, addr_d;
  logic [15:0]          rem_q, rem_d;
  logic [RD_LAT-1:0]    vld_q, vld_d;
  logic [RD_LAT-1:0]    lst_q, lst_d;
  logic                 done_q, done_d;

  logic [BDBANKW-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [PW-1:0]        wptr_q, rptr_q;
  logic [CW-1:0]        occ_q;

  logic [CW-1:0]        inflight;
  logic                 room;
  logic                 req_en;
  logic                 req_acc;
  logic                 push;
  logic                 pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(vld_q[i]);
    end
  end

  // Reads are only issued when every outstanding word already has a FIFO
  // slot reserved, so the FIFO cannot overflow whatever the consumer does.
  assign room    = (occ_q + inflight) < CW'(FIFO_DEPTH);
  assign req_en  = (state_q == ST_REQ) && room;
  assign req_acc = req_en && mvu_rdc_grnt;
  assign push    = vld_q[RD_LAT-1];
  assign pop     = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == 16'd0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = cmd_baddr;
            rem_d   = cmd_len;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        busy = 1'b1;
        if (req_acc) begin
          addr_d = addr_q + BDBANKA'(1);
          rem_d  = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (pop && out_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Each granted read walks this pipe; it lands in the FIFO when it
  // reaches the last stage, exactly RD_LAT cycles after its grant.
  always_comb begin
    vld_d    = '0;
    lst_d    = '0;
    vld_d[0] = req_acc;
    lst_d[0] = req_acc && (rem_q == 16'd1);
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      lst_d[i] = lst_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      vld_q   <= '0;
      lst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
      fifo_last_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      occ_q       <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wptr_q] <= mvu_rdc_word;
        fifo_last_q[wptr_q] <= lst_q[RD_LAT-1];
        wptr_q              <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign mvu_rdc_en   = req_en;
  assign mvu_rdc_addr = addr_q;
  assign out_valid    = (occ_q != '0);
  assign out_data     = fifo_data_q[rptr_q];
  assign out_last     = fifo_last_q[rptr_q];
  assign done         = done_q;

endmodule

// File: tb/tb_mvu_rdc_reader.sv
// Directed bench for mvu_rdc_reader: a latency-accurate memory model returns
// a word derived from each granted address; a monitor logs grants, pops and
// done pulses, and each scenario compares the log against hand-derived values.
module tb_mvu_rdc_reader;

  localparam int A   = 15;
  localparam int W   = 64;
  localparam int RDL = 2;
  localparam int FD  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [A-1:0]  cmd_baddr;
  logic [15:0]   cmd_len;
  logic          mvu_rdc_en;
  logic          mvu_rdc_grnt;
  logic [A-1:0]  mvu_rdc_addr;
  logic [W-1:0]  mvu_rdc_word;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  mvu_rdc_reader #(.BDBANKA(A), .BDBANKW(W), .RD_LAT(RDL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_baddr(cmd_baddr), .cmd_len(cmd_len),
    .mvu_rdc_en(mvu_rdc_en), .mvu_rdc_grnt(mvu_rdc_grnt),
    .mvu_rdc_addr(mvu_rdc_addr), .mvu_rdc_word(mvu_rdc_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mkw(input logic [A-1:0] a);
    return 64'hC0DE_F00D_0000_0000 | 64'(a);
  endfunction

  // memory model: not reset, so reads granted before a DUT reset still return
  logic [RDL-1:0] pv = '0;
  logic [A-1:0]   pa0 = '0, pa1 = '0;
  always @(posedge clk) begin
    pv  <= {pv[0], mvu_rdc_en && mvu_rdc_grnt};
    pa0 <= mvu_rdc_addr;
    pa1 <= pa0;
  end
  assign mvu_rdc_word = pv[RDL-1] ? mkw(pa1) : 64'hBAD0_BAD0_BAD0_BAD0;

  // monitor
  int           cyc = 0;
  logic [A-1:0] gq[$];
  int           gcyc[$];
  logic [W-1:0] pq[$];
  logic         lq[$];
  int           pcyc[$];
  int           done_n, done_cyc, acc_cyc, hold_viol;
  bit           en_seen, busy_seen, prev_hold;
  logic [A-1:0] prev_addr;

  always @(posedge clk) begin
    if (mvu_rdc_en && mvu_rdc_grnt) begin gq.push_back(mvu_rdc_addr); gcyc.push_back(cyc); end
    if (out_valid && out_ready) begin pq.push_back(out_data); lq.push_back(out_last); pcyc.push_back(cyc); end
    if (done) begin done_n++; done_cyc = cyc; end
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (mvu_rdc_en) en_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (prev_hold && (!mvu_rdc_en || mvu_rdc_addr != prev_addr)) hold_viol++;
    prev_hold = mvu_rdc_en && !mvu_rdc_grnt;
    prev_addr = mvu_rdc_addr;
    cyc++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    gq.delete(); gcyc.delete(); pq.delete(); lq.delete(); pcyc.delete();
    done_n = 0; done_cyc = -1; acc_cyc = -1; hold_viol = 0;
    en_seen = 1'b0; busy_seen = 1'b0; prev_hold = 1'b0;
  endtask

  int  stall_g;
  bit  stall_en, stall_ov;

  // gmode 0: grant every cycle, 1: grant on alternate cycles.
  // out_ready is held low for the first 'stall' cycles.
  task automatic run_cmd(input logic [A-1:0] ba, input logic [15:0] len,
                         input int gmode, input int stall, input int budget);
    clear_log();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_baddr = ba; cmd_len = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_baddr = '0; cmd_len = '0;
    for (int k = 0; k < budget && done_n == 0; k++) begin
      if (k == stall) begin
        stall_g = gq.size(); stall_en = mvu_rdc_en; stall_ov = out_valid;
      end
      mvu_rdc_grnt = (gmode == 0) ? 1'b1 : (k % 2 == 0);
      out_ready    = (k >= stall);
      @(posedge clk); #1;
    end
    mvu_rdc_grnt = 1'b0;
    out_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string nm, input logic [A-1:0] ba, input int len);
    logic [A-1:0] ea;
    chk({nm, "_ngrant"}, 64'(gq.size()), 64'(len));
    for (int i = 0; i < gq.size(); i++) begin
      ea = ba + A'(i);
      chk({nm, "_gaddr"}, 64'(gq[i]), 64'(ea));
    end
    chk({nm, "_nword"}, 64'(pq.size()), 64'(len));
    for (int i = 0; i < pq.size(); i++) begin
      ea = ba + A'(i);
      chk({nm, "_data"}, pq[i], mkw(ea));
      chk({nm, "_last"}, 64'(lq[i]), 64'(i == len - 1));
    end
    chk({nm, "_done_n"}, 64'(done_n), 64'd1);
    if (pcyc.size() > 0) chk({nm, "_done_lat"}, 64'(done_cyc), 64'(pcyc[pcyc.size()-1] + 1));
    chk({nm, "_busy_end"}, 64'(busy), 64'd0);
    chk({nm, "_rdy_end"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_baddr = '0; cmd_len = '0;
    mvu_rdc_grnt = 1'b0; out_ready = 1'b1;
    stall_g = -1; stall_en = 1'b1; stall_ov = 1'b0;
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", 64'(mvu_rdc_en), 64'd0);
    chk("rst_addr", 64'(mvu_rdc_addr), 64'd0);
    chk("rst_oval", 64'(out_valid), 64'd0);
    chk("rst_odata", out_data, 64'd0);
    chk("rst_olast", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", 64'(cmd_ready), 64'd1);

    // basic burst, back-to-back grants
    run_cmd(15'h0010, 16'd4, 0, 0, 100);
    check_run("t1", 15'h0010, 4);
    if (gcyc.size() == 4) chk("t1_b2b", 64'(gcyc[3] - gcyc[0]), 64'd3);
    else chk("t1_b2b_cnt", 64'(gcyc.size()), 64'd4);

    // alternating grant: address must hold while refused
    run_cmd(15'h0020, 16'd8, 1, 0, 200);
    check_run("t2", 15'h0020, 8);
    chk("t2_hold", 64'(hold_viol), 64'd0);

    // consumer stalled: only FIFO_DEPTH reads may be outstanding
    run_cmd(15'h0030, 16'd10, 0, 12, 300);
    chk("t3_stall_grants", 64'(stall_g), 64'(FD));
    chk("t3_stall_en", 64'(stall_en), 64'd0);
    chk("t3_stall_oval", 64'(stall_ov), 64'd1);
    check_run("t3", 15'h0030, 10);

    // address wrap
    run_cmd(15'h7FFE, 16'd4, 0, 0, 100);
    check_run("t4", 15'h7FFE, 4);

    // zero length
    run_cmd(15'h0055, 16'd0, 0, 0, 20);
    chk("t5_ngrant", 64'(gq.size()), 64'd0);
    chk("t5_en_seen", 64'(en_seen), 64'd0);
    chk("t5_busy_seen", 64'(busy_seen), 64'd0);
    chk("t5_done_n", 64'(done_n), 64'd1);
    chk("t5_done_lat", 64'(done_cyc), 64'(acc_cyc + 1));

    // reset in the middle of a 6-word command
    clear_log();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_baddr = 15'h0040; cmd_len = 16'd6;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    mvu_rdc_grnt = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 20 && gq.size() < 3; k++) begin
      @(posedge clk); #1;
    end
    chk("t6_pre_grants", 64'(gq.size()), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_en", 64'(mvu_rdc_en), 64'd0);
    chk("t6_addr", 64'(mvu_rdc_addr), 64'd0);
    chk("t6_oval", 64'(out_valid), 64'd0);
    chk("t6_odata", out_data, 64'd0);
    chk("t6_olast", 64'(out_last), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    mvu_rdc_grnt = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_late_pops", 64'(pq.size()), 64'd0);
    chk("t6_late_oval", 64'(out_valid), 64'd0);
    chk("t6_rdy", 64'(cmd_ready), 64'd1);
    run_cmd(15'h0050, 16'd2, 0, 0, 100);
    check_run("t6", 15'h0050, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
